// File: rtl/rca_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
package rca_ctrl_pkg;

    localparam int unsigned SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    // Operand width must be a whole, non-zero number of adder slices.
    function automatic bit width_ok(input int unsigned w);
        return (w >= SLICE_W) && ((w % SLICE_W) == 0);
    endfunction

endpackage

// File: rtl/RCA_4bit.sv
// 4-bit ripple-carry adder built from chained full adders.
module RCA_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] c;

    // Ripple the carry through four full-adder stages.
    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < 4; i++) begin
            sum[i]  = a[i] ^ b[i] ^ c[i];
            c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[4];
    end

endmodule

// File: rtl/rca_seq_ctrl.sv
// Wide adder that reuses one RCA_4bit, one nibble per clock, with
// valid/ready handshakes on the operand and result sides.
module rca_seq_ctrl
    import rca_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NSLICE = WIDTH / SLICE_W;
    localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    if (!width_ok(WIDTH)) begin : g_width_check
        $fatal(1, "rca_seq_ctrl: WIDTH must be a multiple of 4 and at least 4");
    end

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [SLICE_W-1:0] a_s, b_s, rca_sum;
    logic               rca_cout;
    logic               last_slice;

    RCA_4bit u_rca (
        .a    (a_s),
        .b    (b_s),
        .cin  (carry_q),
        .sum  (rca_sum),
        .cout (rca_cout)
    );

    // Slice mux, sum demux, next-state and handshake outputs.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        sum_d      = sum_q;
        idx_d      = idx_q;
        carry_d    = carry_q;
        cout_d     = cout_q;
        ovf_d      = ovf_q;
        a_s        = '0;
        b_s        = '0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        last_slice = (idx_q == IDX_W'(NSLICE - 1));

        for (int unsigned i = 0; i < NSLICE; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_s = a_q[i*SLICE_W +: SLICE_W];
                b_s = b_q[i*SLICE_W +: SLICE_W];
            end
        end

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int unsigned i = 0; i < NSLICE; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        sum_d[i*SLICE_W +: SLICE_W] = rca_sum;
                    end
                end
                carry_d = rca_cout;
                if (last_slice) begin
                    cout_d  = rca_cout;
                    // RCA_4bit hides its internal carries; recover the carry into the MSB from its sum bit.
                    ovf_d   = (a_s[SLICE_W-1] ^ b_s[SLICE_W-1] ^ rca_sum[SLICE_W-1]) ^ rca_cout;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Directed bench for rca_seq_ctrl at WIDTH=16 and WIDTH=4.
module tb_rca_seq_ctrl;

    logic clk;
    logic rst_n;

    logic        iv16, ir16, ci16, ov16, or16, co16, vf16;
    logic [15:0] a16, b16, s16;

    logic        iv4, ir4, ci4, ov4, or4, co4, vf4;
    logic [3:0]  a4, b4, s4;

    int checks   = 0;
    int failures = 0;

    rca_seq_ctrl #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv16), .in_ready(ir16),
        .a(a16), .b(b16), .cin(ci16),
        .out_valid(ov16), .out_ready(or16),
        .sum(s16), .cout(co16), .ovf(vf16)
    );

    rca_seq_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv4), .in_ready(ir4),
        .a(a4), .b(b4), .cin(ci4),
        .out_valid(ov4), .out_ready(or4),
        .sum(s4), .cout(co4), .ovf(vf4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands in IDLE and take the accept edge.
    task automatic start16(input logic [15:0] a, input logic [15:0] b, input logic c);
        a16 = a; b16 = b; ci16 = c; iv16 = 1'b1;
        chk("in_ready_before_accept", 32'(ir16), 32'd1);
        tick();
        iv16 = 1'b0;
        chk("in_ready_in_run", 32'(ir16), 32'd0);
    endtask

    // Count the cycle (after the accept edge) in which out_valid first shows.
    task automatic wait16(input string tag, input int exp_cycle);
        int n = 1;
        while (!ov16 && n < 20) begin
            tick();
            n++;
        end
        chk(tag, 32'(n), 32'(exp_cycle));
    endtask

    task automatic result16(input string tag, input logic [15:0] s, input logic c, input logic v);
        chk({tag, "_sum"},  32'(s16), 32'(s));
        chk({tag, "_cout"}, 32'(co16), 32'(c));
        chk({tag, "_ovf"},  32'(vf16), 32'(v));
    endtask

    task automatic release16();
        or16 = 1'b1;
        tick();
        or16 = 1'b0;
        chk("out_valid_after_release", 32'(ov16), 32'd0);
        chk("in_ready_after_release", 32'(ir16), 32'd1);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        iv16 = 1'b0; a16 = '0; b16 = '0; ci16 = 1'b0; or16 = 1'b0;
        iv4  = 1'b0; a4  = '0; b4  = '0; ci4  = 1'b0; or4  = 1'b0;
        #12;
        chk("rst_in_ready",  32'(ir16), 32'd1);
        chk("rst_out_valid", 32'(ov16), 32'd0);
        chk("rst_sum",       32'(s16),  32'd0);
        chk("rst_cout",      32'(co16), 32'd0);
        chk("rst_ovf",       32'(vf16), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        start16(16'h1234, 16'h1111, 1'b0);
        wait16("lat16_basic", 5);
        result16("basic", 16'h2345, 1'b0, 1'b0);
        release16();

        start16(16'hFFFF, 16'h0001, 1'b0);
        wait16("lat16_ripple", 5);
        result16("ripple", 16'h0000, 1'b1, 1'b0);
        release16();

        start16(16'h7FFF, 16'h0001, 1'b0);
        wait16("lat16_posovf", 5);
        result16("posovf", 16'h8000, 1'b0, 1'b1);
        release16();

        start16(16'h8000, 16'h8000, 1'b0);
        wait16("lat16_negovf", 5);
        result16("negovf", 16'h0000, 1'b1, 1'b1);

        // Backpressure: new operands offered while the result is held.
        a16 = 16'hAAAA; b16 = 16'h5555; ci16 = 1'b0; iv16 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_out_valid", 32'(ov16), 32'd1);
            chk("bp_in_ready",  32'(ir16), 32'd0);
            result16("bp_hold", 16'h0000, 1'b1, 1'b1);
        end
        or16 = 1'b1;
        tick();
        or16 = 1'b0;
        chk("bp_idle_out_valid", 32'(ov16), 32'd0);
        chk("bp_idle_in_ready",  32'(ir16), 32'd1);
        tick();
        iv16 = 1'b0;
        chk("bp_accepted", 32'(ir16), 32'd0);
        wait16("lat16_bp", 5);
        result16("bp_next", 16'hFFFF, 1'b0, 1'b0);
        release16();

        // Asynchronous abort in the second RUN cycle.
        start16(16'h1234, 16'h4321, 1'b1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(ov16), 32'd0);
        chk("abort_in_ready",  32'(ir16), 32'd1);
        chk("abort_sum",       32'(s16),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ov16) n++;
        end
        chk("abort_no_valid_pulse", 32'(n), 32'd0);
        start16(16'h0F0F, 16'h00F1, 1'b1);
        wait16("lat16_after_abort", 5);
        result16("after_abort", 16'h1001, 1'b0, 1'b0);
        release16();

        // Single-slice instance.
        a4 = 4'h9; b4 = 4'h6; ci4 = 1'b1; iv4 = 1'b1;
        chk("w4_in_ready", 32'(ir4), 32'd1);
        tick();
        iv4 = 1'b0;
        n = 1;
        while (!ov4 && n < 20) begin
            tick();
            n++;
        end
        chk("lat4", 32'(n), 32'd2);
        chk("w4_sum",  32'(s4),  32'h0);
        chk("w4_cout", 32'(co4), 32'd1);
        chk("w4_ovf",  32'(vf4), 32'd0);
        or4 = 1'b1;
        tick();
        or4 = 1'b0;
        chk("w4_release", 32'(ov4), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
